// File: rtl/icache_ctrl_pkg.sv
// icache_ctrl_pkg: FSM states, line geometry and address-field helpers shared by the icache slice
package icache_ctrl_pkg;

    localparam int WORDS_PER_LINE = 4;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOOKUP   = 3'd1,
        ST_MISS_REQ = 3'd2,
        ST_REFILL   = 3'd3,
        ST_RESP     = 3'd4
    } state_e;

    function automatic int tag_lsb(input int idx_bit, input int off_bit);
        return idx_bit + off_bit;
    endfunction

    function automatic int tag_w(input int idx_bit, input int off_bit);
        return 32 - tag_lsb(idx_bit, off_bit);
    endfunction

endpackage

// File: rtl/icache_line_store.sv
// icache_line_store: direct-mapped valid/tag/data arrays, combinational read, synchronous write
module icache_line_store
    import icache_ctrl_pkg::*;
#(
    parameter int IDX_BIT = 4,
    parameter int TAG_W   = 24
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr_all_i,
    input  logic [IDX_BIT-1:0] idx_i,
    input  logic [1:0]         rd_word_i,
    output logic               rd_valid_o,
    output logic [TAG_W-1:0]   rd_tag_o,
    output logic [31:0]        rd_data_o,
    input  logic               wr_en_i,
    input  logic [1:0]         wr_word_i,
    input  logic [31:0]        wr_data_i,
    input  logic               set_valid_i,
    input  logic [TAG_W-1:0]   set_tag_i
);

    localparam int LINES = 1 << IDX_BIT;

    logic [LINES-1:0] valid_q;
    logic [TAG_W-1:0] tag_q [LINES];
    logic [31:0]      data_q [LINES][WORDS_PER_LINE];

    assign rd_valid_o = valid_q[idx_i];
    assign rd_tag_o   = tag_q[idx_i];
    assign rd_data_o  = data_q[idx_i][rd_word_i];

    // valid bits: cleared wholesale by reset or flush, set when a refill completes
    always_ff @(posedge clk) begin
        if (rst || clr_all_i) valid_q <= '0;
        else if (set_valid_i) valid_q[idx_i] <= 1'b1;
    end

    // payload arrays: refill beats and the tag need no reset, valid gates their use
    always_ff @(posedge clk) begin
        if (wr_en_i) data_q[idx_i][wr_word_i] <= wr_data_i;
        if (set_valid_i) tag_q[idx_i] <= set_tag_i;
    end

endmodule

// File: rtl/icache_ctrl.sv
// icache_ctrl: blocking direct-mapped instruction cache controller; ICACHE_CTRL_PERF_EN adds hit/miss counters
module icache_ctrl
    import icache_ctrl_pkg::*;
#(
    parameter int IDX_BIT = 4,
    parameter int OFF_BIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic [31:0] cpu_addr,
    output logic        cpu_ready,
    output logic        cpu_rvalid,
    output logic [31:0] cpu_rdata,
    input  logic        flush,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
`ifdef ICACHE_CTRL_PERF_EN
    ,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
`endif
);

    localparam int TAG_LSB = tag_lsb(IDX_BIT, OFF_BIT);
    localparam int TAG_W   = tag_w(IDX_BIT, OFF_BIT);

    localparam logic [2:0] S_IDLE     = ST_IDLE;
    localparam logic [2:0] S_LOOKUP   = ST_LOOKUP;
    localparam logic [2:0] S_MISS_REQ = ST_MISS_REQ;
    localparam logic [2:0] S_REFILL   = ST_REFILL;
    localparam logic [2:0] S_RESP     = ST_RESP;

    logic [2:0]         state_q, state_d;
    logic [31:2]        addr_q, addr_d;
    logic [1:0]         beat_q, beat_d;
    logic               pend_q, pend_d;
    logic               accept, hit, clr_all, wr_en, last_beat;
    logic               rd_valid;
    logic [TAG_W-1:0]   rd_tag, tag;
    logic [IDX_BIT-1:0] idx;
    logic [31:0]        rd_data;
    logic               unused_addr_bits;

    assign unused_addr_bits = ^cpu_addr[1:0];

    assign tag       = addr_q[31:TAG_LSB];
    assign idx       = addr_q[TAG_LSB-1:OFF_BIT];
    assign cpu_ready = state_q == S_IDLE && !flush;
    assign accept    = cpu_req && cpu_ready;
    assign hit       = rd_valid && rd_tag == tag;
    // a pending flush lands in IDLE, i.e. after any refill write of the transaction that saw it
    assign clr_all   = state_q == S_IDLE && (flush || pend_q);
    assign wr_en     = state_q == S_REFILL && mem_rvalid;
    assign last_beat = wr_en && beat_q == 2'd3;

    assign cpu_rvalid = (state_q == S_LOOKUP && hit) || state_q == S_RESP;
    assign cpu_rdata  = cpu_rvalid ? rd_data : 32'd0;
    assign mem_req    = state_q == S_MISS_REQ;
    assign mem_addr   = mem_req ? {addr_q[31:OFF_BIT], {OFF_BIT{1'b0}}} : 32'd0;

    icache_line_store #(
        .IDX_BIT(IDX_BIT),
        .TAG_W  (TAG_W)
    ) u_store (
        .clk        (clk),
        .rst        (rst),
        .clr_all_i  (clr_all),
        .idx_i      (idx),
        .rd_word_i  (addr_q[3:2]),
        .rd_valid_o (rd_valid),
        .rd_tag_o   (rd_tag),
        .rd_data_o  (rd_data),
        .wr_en_i    (wr_en),
        .wr_word_i  (beat_q),
        .wr_data_i  (mem_rdata),
        .set_valid_i(last_beat),
        .set_tag_i  (tag)
    );

    // next state: one request at a time, miss path walks request, refill, response
    always_comb begin
        state_d = S_IDLE;
        case (state_q)
            S_IDLE:     state_d = accept ? S_LOOKUP : S_IDLE;
            S_LOOKUP:   state_d = hit ? S_IDLE : S_MISS_REQ;
            S_MISS_REQ: state_d = mem_ack ? S_REFILL : S_MISS_REQ;
            S_REFILL:   state_d = last_beat ? S_RESP : S_REFILL;
            default:    state_d = S_IDLE;
        endcase
    end

    // datapath next values: request address, refill beat index, deferred flush
    always_comb begin
        addr_d = accept ? cpu_addr[31:2] : addr_q;
        beat_d = state_q == S_MISS_REQ ? 2'd0 : wr_en ? beat_q + 2'd1 : beat_q;
        pend_d = clr_all ? 1'b0 : (flush && state_q != S_IDLE) ? 1'b1 : pend_q;
    end

    // controller registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            beat_q  <= 2'd0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            beat_q  <= beat_d;
            pend_q  <= pend_d;
        end
    end

`ifdef ICACHE_CTRL_PERF_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;

    // lookup outcome counters, free-running modulo 2^32
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt_q  <= 32'd0;
            miss_cnt_q <= 32'd0;
        end else if (state_q == S_LOOKUP) begin
            hit_cnt_q  <= hit ? hit_cnt_q + 32'd1 : hit_cnt_q;
            miss_cnt_q <= hit ? miss_cnt_q : miss_cnt_q + 32'd1;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_icache_ctrl.sv
// tb_icache_ctrl: directed table, corner sequences and randomized reads against a line-level cache model
module tb_icache_ctrl;

    logic        clk = 1'b0;
    logic        rst, cpu_req, flush, mem_ack, mem_rvalid;
    logic [31:0] cpu_addr, mem_rdata, cpu_rdata, mem_addr;
    logic        cpu_ready, cpu_rvalid, mem_req;
`ifdef ICACHE_CTRL_PERF_EN
    logic [31:0] hit_cnt, miss_cnt;
`endif

    int total = 0;
    int bad   = 0;
    int nh    = 0;
    int nm    = 0;

    logic        mv [16];
    logic [23:0] mt [16];
    logic [31:0] md [16][4];
    logic [31:0] bw [4];

    typedef struct {
        logic [31:0] a;
        logic [31:0] wbase;
        logic        hit;
        logic [31:0] exp;
        int          dly;
        int          gap;
    } vec_t;

    vec_t tbl [6];

    always #5 clk = ~clk;

    icache_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_req   (cpu_req),
        .cpu_addr  (cpu_addr),
        .cpu_ready (cpu_ready),
        .cpu_rvalid(cpu_rvalid),
        .cpu_rdata (cpu_rdata),
        .flush     (flush),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_rvalid(mem_rvalid),
        .mem_rdata (mem_rdata)
`ifdef ICACHE_CTRL_PERF_EN
        ,
        .hit_cnt   (hit_cnt),
        .miss_cnt  (miss_cnt)
`endif
    );

    task automatic chk(input string nm_s, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm_s, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] memw(input logic [31:0] line, input int b);
        return (line + 32'(b) * 32'd4) * 32'h9E37_79B1 + 32'h1234_5678;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 16; i++) mv[i] = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        model_clear();
        nh = 0;
        nm = 0;
    endtask

    // one CPU read; miss path plays the memory side with the given ack delay and beat gaps
    task automatic rd(input logic [31:0] a, input logic exp_hit, input logic [31:0] exp_d,
                      input int dly, input int gap, input logic fl_mid);
        logic [31:0] line;
        logic [3:0]  ix;
        line = {a[31:4], 4'h0};
        ix   = a[7:4];
        cpu_req  = 1'b1;
        cpu_addr = a;
        @(negedge clk);
        chk("accept_ready", {31'd0, cpu_ready}, 32'd1);
        chk("idle_rvalid", {31'd0, cpu_rvalid}, 32'd0);
        chk("idle_rdata", cpu_rdata, 32'd0);
        cyc();
        cpu_req  = 1'b0;
        cpu_addr = $urandom;
        @(negedge clk);
        if (exp_hit) begin
            nh++;
            chk("hit_rvalid", {31'd0, cpu_rvalid}, 32'd1);
            chk("hit_rdata", cpu_rdata, exp_d);
            chk("hit_memreq", {31'd0, mem_req}, 32'd0);
            cyc();
        end else begin
            nm++;
            chk("miss_rvalid", {31'd0, cpu_rvalid}, 32'd0);
            chk("miss_rdata", cpu_rdata, 32'd0);
            cyc();
            for (int i = 0; i < dly; i++) begin
                mem_rvalid = (i == 0);
                @(negedge clk);
                chk("stall_memreq", {31'd0, mem_req}, 32'd1);
                chk("stall_memaddr", mem_addr, line);
                cyc();
                mem_rvalid = 1'b0;
            end
            mem_ack = 1'b1;
            @(negedge clk);
            chk("memreq", {31'd0, mem_req}, 32'd1);
            chk("memaddr", mem_addr, line);
            cyc();
            mem_ack = 1'b0;
            for (int b = 0; b < 4; b++) begin
                for (int g = 0; g < gap; g++) begin
                    mem_ack = (g == 0);
                    @(negedge clk);
                    chk("gap_rvalid", {31'd0, cpu_rvalid}, 32'd0);
                    chk("gap_memreq", {31'd0, mem_req}, 32'd0);
                    cyc();
                    mem_ack = 1'b0;
                end
                mem_rvalid = 1'b1;
                mem_rdata  = bw[b];
                flush      = fl_mid && b == 2;
                cyc();
                mem_rvalid = 1'b0;
                flush      = 1'b0;
                mem_rdata  = $urandom;
            end
            @(negedge clk);
            chk("resp_rvalid", {31'd0, cpu_rvalid}, 32'd1);
            chk("resp_rdata", cpu_rdata, exp_d);
            chk("resp_memreq", {31'd0, mem_req}, 32'd0);
            cyc();
            mv[ix] = 1'b1;
            mt[ix] = a[31:8];
            for (int b = 0; b < 4; b++) md[ix][b] = bw[b];
            if (fl_mid) model_clear();
        end
    endtask

    // flush pulse in IDLE, optionally colliding with a request that must be refused
    task automatic idle_flush(input logic req);
        cpu_req  = req;
        cpu_addr = $urandom;
        flush    = 1'b1;
        @(negedge clk);
        chk("flush_ready", {31'd0, cpu_ready}, 32'd0);
        cyc();
        flush   = 1'b0;
        cpu_req = 1'b0;
        @(negedge clk);
        chk("flush_still_idle", {31'd0, cpu_ready}, 32'd1);
        chk("flush_rvalid", {31'd0, cpu_rvalid}, 32'd0);
        cyc();
        model_clear();
    endtask

    task automatic set_words(input logic [31:0] base);
        for (int b = 0; b < 4; b++) bw[b] = base + 32'(b);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, exp_d, line;
        logic [3:0]  ix;
        logic        h, fm;
        tbl[0] = '{32'h0000_1004, 32'hA0, 1'b0, 32'hA1, 0, 0};
        tbl[1] = '{32'h0000_100C, 32'hA0, 1'b1, 32'hA3, 0, 0};
        tbl[2] = '{32'h0000_2004, 32'hB0, 1'b0, 32'hB1, 5, 3};
        tbl[3] = '{32'h0000_1004, 32'hA0, 1'b0, 32'hA1, 0, 0};
        tbl[4] = '{32'h0000_2007, 32'hB0, 1'b0, 32'hB1, 2, 1};
        tbl[5] = '{32'h0000_2008, 32'hB0, 1'b1, 32'hB2, 0, 0};
        cpu_req = 1'b0; cpu_addr = 32'd0; flush = 1'b0;
        mem_ack = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
        do_reset();
        @(negedge clk);
        chk("rst_ready", {31'd0, cpu_ready}, 32'd1);
        chk("rst_rvalid", {31'd0, cpu_rvalid}, 32'd0);
        chk("rst_rdata", cpu_rdata, 32'd0);
        chk("rst_memreq", {31'd0, mem_req}, 32'd0);
        chk("rst_memaddr", mem_addr, 32'd0);
        cyc();

        for (int i = 0; i < 6; i++) begin
            set_words(tbl[i].wbase);
            rd(tbl[i].a, tbl[i].hit, tbl[i].exp, tbl[i].dly, tbl[i].gap, 1'b0);
        end

        idle_flush(1'b1);
        set_words(32'hB0);
        rd(32'h0000_2004, 1'b0, 32'hB1, 1, 0, 1'b0);

        set_words(32'hC0);
        rd(32'h0000_3018, 1'b0, 32'hC2, 0, 1, 1'b1);
        rd(32'h0000_3018, 1'b0, 32'hC2, 0, 0, 1'b0);
        set_words(32'hB0);
        rd(32'h0000_2004, 1'b0, 32'hB1, 0, 0, 1'b0);

        mem_ack = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("spurious_memreq", {31'd0, mem_req}, 32'd1 - 32'd1);
        cyc();
        mem_ack = 1'b0; mem_rvalid = 1'b0;
        @(negedge clk);
        chk("spurious_idle", {31'd0, cpu_ready}, 32'd1);
        cyc();
        rd(32'h0000_2008, 1'b1, 32'hB2, 0, 0, 1'b0);

        cpu_req = 1'b1; cpu_addr = 32'h0000_4024;
        cyc();
        cpu_req = 1'b0;
        cyc();
        mem_ack = 1'b1;
        cyc();
        mem_ack = 1'b0;
        for (int b = 0; b < 2; b++) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 32'hD0 + 32'(b);
            cyc();
        end
        mem_rvalid = 1'b0;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        model_clear();
        @(negedge clk);
        chk("midrst_ready", {31'd0, cpu_ready}, 32'd1);
        chk("midrst_memreq", {31'd0, mem_req}, 32'd0);
        chk("midrst_memaddr", mem_addr, 32'd0);
        chk("midrst_rvalid", {31'd0, cpu_rvalid}, 32'd0);
        cyc();
        set_words(32'hD0);
        rd(32'h0000_4024, 1'b0, 32'hD1, 0, 0, 1'b0);
        rd(32'h0000_402C, 1'b1, 32'hD3, 0, 0, 1'b0);

        do_reset();
        for (int t = 0; t < 200; t++) begin
            if ($urandom_range(0, 11) == 0) idle_flush(1'($urandom_range(0, 1)));
            a  = {24'($urandom_range(0, 3)) * 24'h01_0001, 4'($urandom_range(0, 3)), 4'($urandom_range(0, 15))};
            ix = a[7:4];
            line = {a[31:4], 4'h0};
            h  = mv[ix] && mt[ix] == a[31:8];
            for (int b = 0; b < 4; b++) bw[b] = memw(line, b);
            exp_d = h ? md[ix][a[3:2]] : bw[a[3:2]];
            fm = $urandom_range(0, 7) == 0;
            rd(a, h, exp_d, $urandom_range(0, 3), $urandom_range(0, 2), fm);
        end
`ifdef ICACHE_CTRL_PERF_EN
        chk("perf_hits", hit_cnt, 32'(nh));
        chk("perf_misses", miss_cnt, 32'(nm));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
